mult_share_ctrl: RTL and testbench
==================================

// Module: mult_share_ctrl
// PURPOSE
//  Round-robin controller that time-shares one combinational 4x4 unsigned array
//  multiplier among NREQ requesters. Each requester hands over X/Y with a
//  valid/ready handshake and receives its 8-bit product with a valid/ready handshake.
//  Operands and product are registered around the multiplier. At most one operation
//  is in flight.
// PARAMETERS
//  NREQ  4  number of requesters (2..8)
//  W     4  operand width; fixed at 4 to match the array multiplier; product is 2*W
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   NREQ      requester i presents operands
//  req_ready  out  NREQ      one-hot grant: operands of requester i accepted this cycle
//  req_x      in   NREQ*W    operand X, requester i at [i*W +: W]
//  req_y      in   NREQ*W    operand Y, requester i at [i*W +: W]
//  rsp_valid  out  NREQ      one-hot: product for requester i is on rsp_p
//  rsp_ready  in   NREQ      requester i consumes the product
//  rsp_p      out  2*W       product X*Y (unsigned)
//  rsp_id     out  3         index of the requester owning rsp_p
//  busy       out  1         high in MUL or RESP
// BEHAVIOUR
//  Reset values
//  - Reset state: IDLE.
//  - Output reset values: req_ready=0, rsp_valid=0, rsp_p=0, rsp_id=0, busy=0.
//  - Round-robin pointer resets to NREQ-1, so requester 0 has first priority.
//  FSM: IDLE -> MUL -> RESP -> IDLE
//  - IDLE
//    - g = first i with req_valid[i], searching from ptr+1 upward with wrap.
//    - req_ready[g]=1 combinationally in the same cycle; no other ready bit is high.
//    - Latch x_r, y_r and id_r=g, then go to MUL.
//    - If no request is valid, stay in IDLE.
//    - req_ready is forced to 0 outside IDLE and while rst=1.
//  - MUL
//    - x_r and y_r drive the multiplier; p_r <= product at the clock edge.
//    - Always go to RESP.
//  - RESP
//    - rsp_valid[id_r]=1, rsp_p=p_r, rsp_id=id_r, all held stable.
//    - On rsp_ready[id_r], set ptr <= id_r and go to IDLE.
//    - rsp_ready bits of other requesters are ignored.
//  Latency and throughput
//  - Grant in cycle N; rsp_valid rises in cycle N+2.
//  - Peak throughput is one operation per 3 cycles.
//  Boundary conditions
//  - Simultaneous requests: exactly one grant per IDLE visit; losers keep their
//    req_valid asserted and are served in rotation. No requester is starved.
//  - A requester that drops req_valid before it is granted loses nothing; no
//    state is recorded for it.
//  - Backpressure: RESP is held indefinitely. No new grant is issued while in RESP.
//  - rst in any state: the in-flight operation is discarded with no response, and
//    all registers return to their reset values on the next edge.
//  - Arithmetic: 15*15 = 225 fits in 8 bits; no overflow case exists.
//  - rsp_p keeps its last value in IDLE; only rsp_valid qualifies it.
// STRUCTURE
//  - Package mult_ctrl_pkg: state encoding (IDLE=2'd0, MUL=2'd1, RESP=2'd2), W,
//    and the product width PW=2*W.
//  - Sub-module array_mult4: combinational 4x4 unsigned array multiplier built
//    from full-adder cells, instantiated once.
//  - Round-robin selection is a function inside this module; it is not a
//    separate sub-module.
// TESTING
//  1. After reset, req0 with x=2, y=4 -> req_ready[0] in the same cycle;
//     rsp_valid[0] 2 cycles later with rsp_p=8'd8 and rsp_id=0.
//  2. Edge values via req3: 15*3 -> 8'd45; 15*15 -> 8'd225; 0*9 -> 8'd0.
//  3. req_valid=4'b1111 after reset, rsp_ready always 1 -> grant order 0,1,2,3
//     with correct products; each response 3 cycles after the previous one.
//  4. rsp_ready low for 5 cycles in RESP while req1 is valid -> rsp_valid, rsp_p
//     and rsp_id stable; req_ready stays 0; req1 is granted only after consumption.
//  5. req0 and req2 valid continuously -> grants alternate 0,2,0,2 for 8 operations.
//  6. rst asserted in MUL -> next cycle all outputs 0 and no response for the
//     dropped operation; then with req_valid=4'b1010 the next grant is req1.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared constants for the time-shared multiplier controller: operand/product
// widths and the legacy-compatible FSM state encoding.
package mult_ctrl_pkg;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/array_mult4.sv
// Combinational 4x4 unsigned array multiplier: rows of ripple full-adder cells
// accumulate shifted partial products, retiring one product bit per row.
module array_mult4
  import mult_ctrl_pkg::*;
(
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic [PW-1:0] p_o
);

  logic [W:0]   acc;
  logic [W-1:0] sum;
  logic         carry;
  logic         pp;

  // acc[W:1] is the running sum still to be combined; acc[0] is the bit just retired.
  always_comb begin
    p_o   = '0;
    sum   = '0;
    carry = 1'b0;
    pp    = 1'b0;
    acc   = {1'b0, a_i & {W{b_i[0]}}};
    p_o[0] = acc[0];
    for (int unsigned i = 1; i < W; i++) begin
      carry = 1'b0;
      for (int unsigned j = 0; j < W; j++) begin
        pp     = a_i[j] & b_i[i];
        sum[j] = acc[j+1] ^ pp ^ carry;
        carry  = (acc[j+1] & pp) | (acc[j+1] & carry) | (pp & carry);
      end
      acc    = {carry, sum};
      p_o[i] = acc[0];
    end
    p_o[PW-1:W] = acc[W:1];
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin controller time-sharing one registered array multiplier among
// NREQ requesters; one operation in flight, IDLE -> MUL -> RESP -> IDLE.
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_x,
  input  logic [NREQ*W-1:0]   req_y,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [2*W-1:0]      rsp_p,
  output logic [2:0]          rsp_id,
  output logic                busy
);

  logic [1:0]     state_q, state_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [2:0]     id_q, id_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [2*W-1:0] p_q, p_d;
  logic [2*W-1:0] prod;
  logic [3:0]     pick;
  logic [W-1:0]   sel_x, sel_y;
  logic           rsp_ack;

  // Returns {found, index}: first valid requester above ptr, then wrapping to 0..ptr.
  function automatic logic [3:0] rr_pick(input logic [NREQ-1:0] valid,
                                         input logic [2:0]      ptr);
    logic       found;
    logic [2:0] sel;
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && (i > 32'(ptr))) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && valid[i] && (i <= 32'(ptr))) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
    return {found, sel};
  endfunction

  array_mult4 u_mult (
    .a_i (x_q),
    .b_i (y_q),
    .p_o (prod)
  );

  always_comb begin
    pick      = rr_pick(req_valid, ptr_q);
    req_ready = '0;
    rsp_valid = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[2:0] == 3'(i)) begin
        sel_x = req_x[i*W +: W];
        sel_y = req_y[i*W +: W];
      end
      req_ready[i] = (state_q == S_IDLE) && !rst && pick[3] && (pick[2:0] == 3'(i));
      rsp_valid[i] = (state_q == S_RESP) && (id_q == 3'(i));
    end
    rsp_ack = |(rsp_valid & rsp_ready);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (pick[3]) begin
          state_d = S_MUL;
          x_d     = sel_x;
          y_d     = sel_y;
          id_d    = pick[2:0];
        end
      end
      S_MUL: begin
        p_d     = prod;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ack) begin
          ptr_d   = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'(NREQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
    end
  end

  assign rsp_p  = p_q;
  assign rsp_id = id_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench: per-requester operation queues feed the DUT; a
// transaction-level model predicts grants, products and response timing.
module tb_mult_share_ctrl;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*4-1:0] req_x, req_y;
  logic [7:0]      rsp_p;
  logic [2:0]      rsp_id;
  logic            busy;

  always #5 clk = ~clk;

  mult_share_ctrl #(.NREQ(NREQ), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: an operation is granted, its product becomes visible two cycles
  // later and stays until its owner consumes it.
  bit m_pend  = 1'b0;
  int m_age   = 0;
  int m_pid   = 0;
  int m_prod  = 0;
  int m_lastp = 0;
  int m_curid = 0;
  int m_ptr   = NREQ - 1;

  logic [7:0] opq [NREQ][$];
  int grant_log[$];
  int rsp_p_log[$];
  int rsp_id_log[$];
  int rsp_cyc_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - ptr - 1 + 2 * NREQ) % NREQ;
      if (v[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  function automatic bit work_left();
    bit any;
    any = m_pend;
    for (int i = 0; i < NREQ; i++) if (opq[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  task automatic drive_inputs();
    logic [7:0] op;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (opq[i].size() > 0) begin
        op = opq[i][0];
        req_valid[i]      = 1'b1;
        req_x[i*4 +: 4]   = op[7:4];
        req_y[i*4 +: 4]   = op[3:0];
      end
    end
  endtask

  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    drive_inputs();
    @(negedge clk);
    g = (!rst && !m_pend) ? ref_pick(req_valid, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = '0;
    if (m_pend && m_age == 2) exp_rv[m_pid] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("rsp_p", 32'(rsp_p), m_lastp);
    chk("rsp_id", 32'(rsp_id), m_curid);
    chk("busy", 32'(busy), 32'(m_pend));
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
    if (!rst && (rsp_valid & rsp_ready) != '0) begin
      rsp_p_log.push_back(int'(rsp_p));
      rsp_id_log.push_back(int'(rsp_id));
      rsp_cyc_log.push_back(cyc);
    end
    @(posedge clk);
    if (rst) begin
      m_pend  = 1'b0;
      m_ptr   = NREQ - 1;
      m_lastp = 0;
      m_curid = 0;
    end else if (g >= 0) begin
      m_pend  = 1'b1;
      m_age   = 1;
      m_pid   = g;
      m_curid = g;
      m_prod  = int'(req_x[g*4 +: 4]) * int'(req_y[g*4 +: 4]);
      void'(opq[g].pop_front());
    end else if (m_pend && m_age == 1) begin
      m_age   = 2;
      m_lastp = m_prod;
    end else if (m_pend && m_age == 2 && rsp_ready[m_pid]) begin
      m_pend = 1'b0;
      m_ptr  = m_pid;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rsp_p_log.delete();
    rsp_id_log.delete();
    rsp_cyc_log.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (work_left() && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", 32'(n < 200), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    rsp_ready = '0;
    drive_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rsp_p", 32'(rsp_p), 0);

    // single request, latency and product
    clear_logs();
    rsp_ready = '1;
    opq[0].push_back({4'd2, 4'd4});
    drain();
    chk("t1_count", rsp_p_log.size(), 1);
    chk("t1_prod", rsp_p_log[0], 8);
    chk("t1_id", rsp_id_log[0], 0);

    // operand edge values on requester 3
    clear_logs();
    opq[3].push_back({4'd15, 4'd3});
    opq[3].push_back({4'd15, 4'd15});
    opq[3].push_back({4'd0, 4'd9});
    drain();
    chk("t2_count", rsp_p_log.size(), 3);
    chk("t2_15x3", rsp_p_log[0], 45);
    chk("t2_15x15", rsp_p_log[1], 225);
    chk("t2_0x9", rsp_p_log[2], 0);
    chk("t2_id", rsp_id_log[2], 3);

    // all four request together
    do_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) opq[i].push_back({4'(2*i+1), 4'(2*i+2)});
    drain();
    chk("t3_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_order", grant_log[i], i);
    chk("t3_p3", rsp_p_log[3], 56);
    for (int i = 1; i < 4; i++) chk("t3_spacing", rsp_cyc_log[i] - rsp_cyc_log[i-1], 3);

    // backpressure in RESP with a competing request
    clear_logs();
    rsp_ready = '0;
    opq[0].push_back({4'd9, 4'd9});
    for (int n = 0; n < 10 && !(m_pend && m_age == 2); n++) cycle();
    chk("t4_in_resp", 32'(m_pend && m_age == 2), 1);
    opq[1].push_back({4'd2, 4'd3});
    repeat (5) cycle();
    chk("t4_no_grant", grant_log.size(), 1);
    rsp_ready = '1;
    drain();
    chk("t4_order", grant_log[1], 1);
    chk("t4_p0", rsp_p_log[0], 81);
    chk("t4_p1", rsp_p_log[1], 6);

    // two contenders alternate
    do_reset();
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      opq[0].push_back(8'($urandom));
      opq[2].push_back(8'($urandom));
    end
    drain();
    chk("t5_count", grant_log.size(), 8);
    for (int k = 0; k < 8; k++) chk("t5_order", grant_log[k], (k % 2) ? 2 : 0);

    // reset during MUL drops the operation and restores priority
    clear_logs();
    opq[0].push_back({4'd5, 4'd5});
    for (int n = 0; n < 10 && !(m_pend && m_age == 1); n++) cycle();
    chk("t6_in_mul", 32'(m_pend && m_age == 1), 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("t6_idle_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_idle_rsp_p", 32'(rsp_p), 0);
    opq[1].push_back({4'd3, 4'd7});
    opq[3].push_back({4'd4, 4'd4});
    drain();
    chk("t6_first_grant", grant_log[1], 1);
    chk("t6_rsp_count", rsp_p_log.size(), 2);
    chk("t6_rsp_id", rsp_id_log[0], 1);

    // randomized traffic with drops, backpressure and occasional reset
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, NREQ - 1));
      if ($urandom_range(0, 2) == 0 && opq[r].size() < 3) opq[r].push_back(8'($urandom));
      r = int'($urandom_range(0, NREQ - 1));
      if ($urandom_range(0, 15) == 0 && opq[r].size() > 0) void'(opq[r].pop_front());
      rsp_ready = NREQ'($urandom);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst       = 1'b0;
    rsp_ready = '1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
